// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage pipeline: scoreboard, stall/bubble/flush control, EX forwarding selects.
// Optional forwarding path is enabled by defining HAZ_FWD_EN.
module hazard_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reg_wr,
  input  logic [4:0]       id_rw,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic             if_stall,
  output logic             id_bubble,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [4:0] rw;
  } sb_entry_t;

  state_t           state_r;
  sb_entry_t        sb_ex_r;
  sb_entry_t        sb_mem_r;
  sb_entry_t        sb_wb_r;
  sb_entry_t        id_entry_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             ex_rs_s;
  logic             ex_rt_s;
  logic             mem_rs_s;
  logic             mem_rt_s;
  logic             hazard_s;
  logic             bubble_in_s;
  logic             unused_s;

  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input sb_entry_t ent);
    return use_src & ent.valid & ent.wr & (ent.rw == src) & (src != 5'd0);
  endfunction

  assign ex_rs_s     = src_match(id_use_rs, id_rs, sb_ex_r);
  assign ex_rt_s     = src_match(id_use_rt, id_rt, sb_ex_r);
  assign mem_rs_s    = src_match(id_use_rs, id_rs, sb_mem_r);
  assign mem_rt_s    = src_match(id_use_rt, id_rt, sb_mem_r);
  assign bubble_in_s = id_bubble | ~id_valid;
  assign id_entry_s  = '{valid: id_valid, wr: id_reg_wr, load: id_is_load, rw: id_rw};

  // WB entry never hazards: the register file writes before it reads in the same cycle.
`ifdef HAZ_FWD_EN
  assign hazard_s = id_valid & sb_ex_r.load & (ex_rs_s | ex_rt_s);
  assign unused_s = ^{sb_wb_r, sb_mem_r.load};
`else
  assign hazard_s = id_valid & (ex_rs_s | ex_rt_s | mem_rs_s | mem_rt_s);
  assign unused_s = ^{sb_wb_r, sb_mem_r.load, sb_ex_r.load};
`endif

  // Pipeline control: a taken branch overrides any stall.
  always_comb begin
    if_stall   = 1'b0;
    id_bubble  = 1'b0;
    flush_ifid = 1'b0;
    if (ex_br_taken) begin
      flush_ifid = 1'b1;
      id_bubble  = 1'b1;
    end else if (hazard_s) begin
      if_stall  = 1'b1;
      id_bubble = 1'b1;
    end else if (state_r == FLUSH) begin
      id_bubble = 1'b1;
    end else begin
      id_bubble = 1'b0;
    end
  end

  // FSM, scoreboard shift and stall counter.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      sb_ex_r     <= '0;
      sb_mem_r    <= '0;
      sb_wb_r     <= '0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        RUN, STALL: begin
          if (ex_br_taken)   state_r <= FLUSH;
          else if (hazard_s) state_r <= STALL;
          else               state_r <= RUN;
        end
        FLUSH:   state_r <= RUN;
        default: state_r <= RUN;
      endcase
      sb_ex_r  <= bubble_in_s ? sb_entry_t'(0) : id_entry_s;
      sb_mem_r <= sb_ex_r;
      sb_wb_r  <= sb_mem_r;
      if (if_stall && (stall_cnt_r != {CNT_W{1'b1}}))
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else
        stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

`ifdef HAZ_FWD_EN
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic [1:0] fwd_a_r;
  logic [1:0] fwd_b_r;

  // Select for the instruction entering EX: nearest producer wins.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (ex_rs_s)       fwd_a_s = 2'b01;
    else if (mem_rs_s) fwd_a_s = 2'b10;
    else               fwd_a_s = 2'b00;
    if (ex_rt_s)       fwd_b_s = 2'b01;
    else if (mem_rt_s) fwd_b_s = 2'b10;
    else               fwd_b_s = 2'b00;
  end

  // Forwarding selects advance with the ID/EX register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else if (bubble_in_s) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else begin
      fwd_a_r <= fwd_a_s;
      fwd_b_r <= fwd_b_s;
    end
  end

  assign fwd_a = fwd_a_r;
  assign fwd_b = fwd_b_r;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed self-checking bench for hazard_sched; state advances on the falling clock edge.
module tb_hazard_sched;
  logic        clk = 1'b1;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        id_use_rs = 1'b0;
  logic        id_use_rt = 1'b0;
  logic        id_reg_wr = 1'b0;
  logic [4:0]  id_rw = 5'd0;
  logic        id_is_load = 1'b0;
  logic        ex_br_taken = 1'b0;
  logic        if_stall;
  logic        id_bubble;
  logic        flush_ifid;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  int total = 0;
  int passed = 0;

  hazard_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_wr(id_reg_wr), .id_rw(id_rw),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .if_stall(if_stall),
    .id_bubble(id_bubble), .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_reg_wr = 1'b0; id_rw = 5'd0; id_is_load = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic wr, input logic [4:0] rw, input logic ld);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_reg_wr = wr; id_rw = rw; id_is_load = ld;
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  task automatic smp();
    @(posedge clk);
  endtask

  task automatic drain();
    idle();
    adv();
    adv();
    adv();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_if_stall", {31'd0, if_stall}, 32'd0);
    chk("rst_id_bubble", {31'd0, id_bubble}, 32'd0);
    chk("rst_flush", {31'd0, flush_ifid}, 32'd0);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    adv();

`ifdef HAZ_FWD_EN
    // add $3,$1,$2 ; sub $4,$3,$5 -> EX forward
    instr(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); adv();
    instr(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); smp();
    chk("alu_adj_nostall", {31'd0, if_stall}, 32'd0);
    adv(); idle(); smp();
    chk("alu_adj_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("alu_adj_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();
    // add ; nop ; sub -> MEM forward
    instr(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); adv();
    idle(); adv();
    instr(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); smp();
    chk("alu_gap_nostall", {31'd0, if_stall}, 32'd0);
    adv(); idle(); smp();
    chk("alu_gap_fwd_a", {30'd0, fwd_a}, 32'd2);
    drain();
    // lw $3 ; add $4,$3,$3 -> one-cycle load-use stall
    instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1); adv();
    instr(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); smp();
    chk("lu_stall", {31'd0, if_stall}, 32'd1);
    chk("lu_bubble", {31'd0, id_bubble}, 32'd1);
    adv(); smp();
    chk("lu_release", {31'd0, if_stall}, 32'd0);
    chk("lu_release_bub", {31'd0, id_bubble}, 32'd0);
    adv(); idle(); smp();
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd2);
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    drain();
`else
    // add $3,$1,$2 ; or $4,$3,$0 -> two stall cycles
    instr(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); smp();
    chk("alu_producer_nostall", {31'd0, if_stall}, 32'd0);
    adv();
    instr(5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); smp();
    chk("alu_stall1", {31'd0, if_stall}, 32'd1);
    chk("alu_bubble1", {31'd0, id_bubble}, 32'd1);
    adv(); smp();
    chk("alu_stall2", {31'd0, if_stall}, 32'd1);
    adv(); smp();
    chk("alu_release", {31'd0, if_stall}, 32'd0);
    chk("alu_cnt", {16'd0, stall_cnt}, 32'd2);
    adv(); idle(); smp();
    chk("alu_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("alu_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();
    // add ; nop ; or -> one stall cycle
    instr(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); adv();
    idle(); adv();
    instr(5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); smp();
    chk("gap_stall", {31'd0, if_stall}, 32'd1);
    adv(); smp();
    chk("gap_release", {31'd0, if_stall}, 32'd0);
    chk("gap_cnt", {16'd0, stall_cnt}, 32'd3);
    drain();
    // add $3 ; or stalled ; bne taken in EX
    instr(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); adv();
    instr(5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); smp();
    chk("br_pre_stall", {31'd0, if_stall}, 32'd1);
    adv();
    ex_br_taken = 1'b1; smp();
    chk("br_flush", {31'd0, flush_ifid}, 32'd1);
    chk("br_no_stall", {31'd0, if_stall}, 32'd0);
    chk("br_bubble", {31'd0, id_bubble}, 32'd1);
    adv();
    ex_br_taken = 1'b0; idle(); smp();
    chk("flush_state_bubble", {31'd0, id_bubble}, 32'd1);
    chk("flush_state_noflush", {31'd0, flush_ifid}, 32'd0);
    adv(); smp();
    chk("run_after_flush", {31'd0, id_bubble}, 32'd0);
    chk("br_cnt", {16'd0, stall_cnt}, 32'd4);
    drain();
`endif

    // add $0 ; consumer of $0 -> never a hazard
    instr(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0); adv();
    instr(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0); smp();
    chk("r0_nostall", {31'd0, if_stall}, 32'd0);
    chk("r0_nobubble", {31'd0, id_bubble}, 32'd0);
    adv(); idle(); smp();
    chk("r0_fwd_a", {30'd0, fwd_a}, 32'd0);
    drain();

    // lw $3 ; add $4,$3,$3 stalled, then reset mid-stall
    instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1); adv();
    instr(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); smp();
    chk("mid_pre_stall", {31'd0, if_stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_if_stall", {31'd0, if_stall}, 32'd0);
    chk("mid_bubble", {31'd0, id_bubble}, 32'd0);
    chk("mid_flush", {31'd0, flush_ifid}, 32'd0);
    chk("mid_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mid_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    #1 rst_n = 1'b1;
    adv(); smp();
    chk("post_rst_nostall", {31'd0, if_stall}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
